// File: rtl/csi2_ppi_tx_packetizer.sv
// CSI-2 packet transmitter for one HS lane of the DPHY_CORE PPI TX byte interface.
// Takes a packet descriptor and a payload byte stream. It sends the 4-byte header with its
// 6-bit Hamming ECC. Long packets then carry the payload and a CRC-16. Each burst is
// followed by a minimum LP gap on TxRequestHS.

module csi2_ppi_tx_packetizer #(
    parameter int GAP_CYCLES = 8,
    parameter int WC_MAX     = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    input  logic        pkt_long,
    input  logic [1:0]  pkt_vc,
    input  logic [5:0]  pkt_dt,
    input  logic [15:0] pkt_wc,
    input  logic [7:0]  pl_data,
    input  logic        pl_valid,
    output logic        pl_ready,
    output logic        txreqhs,
    input  logic        txreadyhs,
    output logic [7:0]  txdatahs,
    output logic        busy,
    output logic        underflow,
    output logic        wc_clamped
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HDR,
        S_PAY,
        S_CRC,
        S_GAP
    } state_t;

    localparam logic [15:0] LP_WC_MAX   = 16'(WC_MAX);
    localparam logic [7:0]  LP_GAP_LAST = 8'(GAP_CYCLES - 1);

    // CSI-2 v1.x header ECC. Each parity bit covers a fixed subset of the 24 header bits.
    // The 24 bits are {WC[15:8], WC[7:0], DI}.
    function automatic logic [7:0] ecc6(input logic [23:0] d);
        logic [5:0] p;
        p[0] = ^(d & 24'hF12CB7);
        p[1] = ^(d & 24'hF2555B);
        p[2] = ^(d & 24'h749A6D);
        p[3] = ^(d & 24'hB8E38E);
        p[4] = ^(d & 24'hDF03F0);
        p[5] = ^(d & 24'hEFFC00);
        return {2'b00, p};
    endfunction

    // One byte of the reflected CRC-16 (x^16+x^12+x^5+1). Data bits are fed LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ 16'h8408;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    state_t      r_state;
    logic        r_pkt_ready;
    logic        r_txreqhs;
    logic [7:0]  r_txdata;
    logic        r_busy;
    logic        r_underflow;
    logic        r_wc_clamped;
    logic        r_long;
    logic [7:0]  r_di;
    logic [15:0] r_wc;
    logic [15:0] r_byte_cnt;
    logic [1:0]  r_hdr_idx;
    logic [15:0] r_crc;
    logic        r_crc_hi;
    logic [7:0]  r_gap_cnt;

    logic        w_clamp;
    logic [15:0] w_wc_in;
    logic [7:0]  w_ecc;
    logic [7:0]  w_pay_byte;
    logic [15:0] w_crc_next;

    // Only long packets are clamped. A short packet's WC field is opaque data.
    assign w_clamp    = pkt_long && (pkt_wc > LP_WC_MAX);
    assign w_wc_in    = w_clamp ? LP_WC_MAX : pkt_wc;
    assign w_ecc      = ecc6({r_wc, r_di});
    // A starved payload slot is filled with 0x00. The CRC covers that filler byte.
    assign w_pay_byte = pl_valid ? pl_data : 8'h00;
    assign w_crc_next = crc16_byte(r_crc, w_pay_byte);

    assign pkt_ready  = r_pkt_ready;
    assign txreqhs    = r_txreqhs;
    assign busy       = r_busy;
    assign underflow  = r_underflow;
    assign wc_clamped = r_wc_clamped;
    // Payload passes straight through to the lane, so a byte is consumed exactly when the PHY takes it.
    assign pl_ready   = (r_state == S_PAY) && txreadyhs;
    assign txdatahs   = (r_state == S_PAY) ? w_pay_byte : r_txdata;

    // Packet sequencer: accept descriptor, request HS, stream header/payload/CRC, then time the gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pkt_ready  <= 1'b0;
            r_txreqhs    <= 1'b0;
            r_txdata     <= 8'h00;
            r_busy       <= 1'b0;
            r_underflow  <= 1'b0;
            r_wc_clamped <= 1'b0;
            r_long       <= 1'b0;
            r_di         <= 8'h00;
            r_wc         <= 16'h0000;
            r_byte_cnt   <= 16'h0000;
            r_hdr_idx    <= 2'd0;
            r_crc        <= 16'hFFFF;
            r_crc_hi     <= 1'b0;
            r_gap_cnt    <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads pre-edge register values.
            case (r_state)
                S_IDLE: begin
                    // pkt_ready rises one cycle after IDLE is entered. This sets the request spacing.
                    if (r_pkt_ready && pkt_valid) begin
                        r_pkt_ready <= 1'b0;
                        r_state     <= S_REQ;
                        r_busy      <= 1'b1;
                        r_txreqhs   <= 1'b1;
                        r_txdata    <= {pkt_vc, pkt_dt};
                        r_di        <= {pkt_vc, pkt_dt};
                        r_wc        <= w_wc_in;
                        r_long      <= pkt_long;
                        r_crc       <= 16'hFFFF;
                        r_crc_hi    <= 1'b0;
                        if (w_clamp) begin
                            r_wc_clamped <= 1'b1;
                        end
                    end else begin
                        r_pkt_ready <= 1'b1;
                    end
                end

                S_REQ: begin
                    // DI is on the bus while waiting. It is taken with the first TxReadyHS.
                    if (txreadyhs) begin
                        r_txdata  <= r_wc[7:0];
                        r_hdr_idx <= 2'd1;
                        r_state   <= S_HDR;
                    end
                end

                S_HDR: begin
                    if (txreadyhs) begin
                        case (r_hdr_idx)
                            2'd1: begin
                                r_txdata  <= r_wc[15:8];
                                r_hdr_idx <= 2'd2;
                            end
                            2'd2: begin
                                r_txdata  <= w_ecc;
                                r_hdr_idx <= 2'd3;
                            end
                            default: begin
                                if (!r_long) begin
                                    r_txreqhs <= 1'b0;
                                    r_txdata  <= 8'h00;
                                    r_gap_cnt <= LP_GAP_LAST;
                                    r_state   <= S_GAP;
                                end else if (r_wc == 16'h0000) begin
                                    r_txdata <= r_crc[7:0];
                                    r_state  <= S_CRC;
                                end else begin
                                    r_byte_cnt <= r_wc;
                                    r_state    <= S_PAY;
                                end
                            end
                        endcase
                    end
                end

                S_PAY: begin
                    if (txreadyhs) begin
                        r_crc      <= w_crc_next;
                        r_byte_cnt <= r_byte_cnt - 16'd1;
                        if (!pl_valid) begin
                            r_underflow <= 1'b1;
                        end
                        if (r_byte_cnt == 16'd1) begin
                            r_txdata <= w_crc_next[7:0];
                            r_crc_hi <= 1'b0;
                            r_state  <= S_CRC;
                        end
                    end
                end

                S_CRC: begin
                    if (txreadyhs) begin
                        if (!r_crc_hi) begin
                            r_txdata <= r_crc[15:8];
                            r_crc_hi <= 1'b1;
                        end else begin
                            r_txreqhs <= 1'b0;
                            r_txdata  <= 8'h00;
                            r_gap_cnt <= LP_GAP_LAST;
                            r_state   <= S_GAP;
                        end
                    end
                end

                S_GAP: begin
                    if (r_gap_cnt == 8'h00) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csi2_ppi_tx_packetizer.sv
// Self-checking bench for csi2_ppi_tx_packetizer. It has a table of short-packet header vectors.
// Hand sequences cover the long-packet corner cases, and randomized packets are checked
// against a byte-stream reference model.

`timescale 1ns/1ps

module tb_csi2_ppi_tx_packetizer;

    localparam int GAP = 8;
    localparam int WCM = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        pkt_valid;
    logic        pkt_ready;
    logic        pkt_long;
    logic [1:0]  pkt_vc;
    logic [5:0]  pkt_dt;
    logic [15:0] pkt_wc;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic        pl_ready;
    logic        txreqhs;
    logic        txreadyhs;
    logic [7:0]  txdatahs;
    logic        busy;
    logic        underflow;
    logic        wc_clamped;

    csi2_ppi_tx_packetizer #(
        .GAP_CYCLES(GAP),
        .WC_MAX    (WCM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt_long  (pkt_long),
        .pkt_vc    (pkt_vc),
        .pkt_dt    (pkt_dt),
        .pkt_wc    (pkt_wc),
        .pl_data   (pl_data),
        .pl_valid  (pl_valid),
        .pl_ready  (pl_ready),
        .txreqhs   (txreqhs),
        .txreadyhs (txreadyhs),
        .txdatahs  (txdatahs),
        .busy      (busy),
        .underflow (underflow),
        .wc_clamped(wc_clamped)
    );

    always #5 clk = ~clk;

    // Short-packet header vectors. The ECC column was worked out by hand from the CSI-2 code table.
    typedef struct {
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] wc;
        logic [7:0]  ecc;
    } short_vec_t;

    short_vec_t tbl [7];

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int last_fall = 0;

    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] pay_src [$];

    int req_cycles;
    int gap_seen;
    int pl_ready_out;
    int pl_consumed;
    int hold_err;

    logic [5:0]  ecc_code [24] = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
                                   6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
                                   6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
    logic [15:0] crc_tab [256];
    logic [7:0]  ex_pay [24] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
                                 8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
                                 8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference ECC: XOR of the syndrome column of every set header bit.
    function automatic logic [7:0] model_ecc(input logic [23:0] d);
        logic [5:0] s;
        s = 6'h00;
        for (int i = 0; i < 24; i++) begin
            if (d[i]) s = s ^ ecc_code[i];
        end
        return {2'b00, s};
    endfunction

    // Reference packet byte stream. A payload slot starved by underflow carries 0x00.
    // The source bytes after that slot shift one position later.
    task automatic build_exp(input logic lng, input logic [1:0] vc, input logic [5:0] dt,
                             input logic [15:0] wc, input int uf_slot);
        logic [15:0] w;
        logic [15:0] crc;
        logic [7:0]  b;
        logic [7:0]  di;
        w  = (lng && wc > 16'(WCM)) ? 16'(WCM) : wc;
        di = {vc, dt};
        exp_q.delete();
        exp_q.push_back(di);
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(model_ecc({w, di}));
        if (lng) begin
            crc = 16'hFFFF;
            for (int i = 0; i < int'(w); i++) begin
                if (uf_slot < 0 || i < uf_slot) b = pay_src[i];
                else if (i == uf_slot)          b = 8'h00;
                else                            b = pay_src[i-1];
                exp_q.push_back(b);
                crc = (crc >> 8) ^ crc_tab[(crc[7:0] ^ b)];
            end
            exp_q.push_back(crc[7:0]);
            exp_q.push_back(crc[15:8]);
        end
    endtask

    task automatic cmp_stream(input string name);
        int n;
        check({name, " length"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s byte %0d", name, i), got_q[i], exp_q[i]);
            if (got_q[i] != exp_q[i]) break;
        end
    endtask

    // Drives one packet. Modes: 0 = ready tied high, 1 = ready low for 5 cycles then toggling,
    // 2 = random ready. Bytes are collected when txreqhs & txreadyhs. The packet ends when the
    // request falls, or when abort_at payload bytes have been taken.
    task automatic run_pkt(input logic lng, input logic [1:0] vc, input logic [5:0] dt,
                           input logic [15:0] wc, input int mode, input int uf_slot,
                           input int abort_at);
        int   idx;
        int   since_req;
        int   wc_eff;
        bit   accepted;
        bit   seen_hi;
        bit   uf_done;
        bit   finished;
        bit   in_pay;
        bit   prev_stall;
        logic [7:0] prev_data;
        got_q.delete();
        req_cycles = 0; pl_ready_out = 0; pl_consumed = 0; hold_err = 0; gap_seen = -1;
        wc_eff = !lng ? 0 : ((wc > 16'(WCM)) ? WCM : int'(wc));
        idx = 0; since_req = 0; accepted = 0; seen_hi = 0; uf_done = 0; finished = 0;
        prev_stall = 0; prev_data = 8'h00;
        pkt_long = lng; pkt_vc = vc; pkt_dt = dt; pkt_wc = wc;
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            cyc++;
            pkt_valid = !accepted;
            case (mode)
                0:       txreadyhs = 1'b1;
                1:       txreadyhs = (since_req < 5) ? 1'b0 : since_req[0];
                default: txreadyhs = ($urandom_range(0, 3) != 0);
            endcase
            in_pay = seen_hi && got_q.size() >= 4 && got_q.size() < 4 + wc_eff;
            pl_valid = (idx < pay_src.size()) &&
                       !(in_pay && uf_slot >= 0 && !uf_done && got_q.size() == 4 + uf_slot);
            pl_data = (idx < pay_src.size()) ? pay_src[idx] : 8'h00;
            #1;
            if (!accepted && pkt_ready) accepted = 1;
            if (txreqhs) begin
                if (!seen_hi) begin
                    seen_hi = 1;
                    gap_seen = cyc - last_fall;
                end
                req_cycles++;
                since_req++;
            end
            if (prev_stall && txreqhs && txdatahs != prev_data) hold_err++;
            prev_stall = txreqhs && !txreadyhs;
            prev_data = txdatahs;
            if (pl_ready) begin
                if (!in_pay) pl_ready_out++;
                else if (pl_valid) begin
                    idx++;
                    pl_consumed++;
                end
            end
            if (in_pay && txreadyhs && !pl_valid && got_q.size() == 4 + uf_slot) uf_done = 1;
            if (txreqhs && txreadyhs) got_q.push_back(txdatahs);
            if (seen_hi && !txreqhs) begin
                last_fall = cyc;
                finished = 1;
                break;
            end
            if (abort_at >= 0 && got_q.size() == 4 + abort_at) begin
                finished = 1;
                break;
            end
        end
        pkt_valid = 1'b0;
        pl_valid = 1'b0;
        if (!finished) check("packet completion", 0, 1);
    endtask

    task automatic load_example();
        pay_src.delete();
        foreach (ex_pay[i]) pay_src.push_back(ex_pay[i]);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] c;
        logic [15:0] rwc;
        logic        rlng;

        tbl[0] = '{vc: 2'd0, dt: 6'h00, wc: 16'h0000, ecc: 8'h00};
        tbl[1] = '{vc: 2'd0, dt: 6'h37, wc: 16'h01F0, ecc: 8'h3F};
        tbl[2] = '{vc: 2'd0, dt: 6'h01, wc: 16'h0000, ecc: 8'h07};
        tbl[3] = '{vc: 2'd3, dt: 6'h00, wc: 16'h0000, ecc: 8'h0F};
        tbl[4] = '{vc: 2'd0, dt: 6'h00, wc: 16'h8000, ecc: 8'h3B};
        tbl[5] = '{vc: 2'd0, dt: 6'h00, wc: 16'h0001, ecc: 8'h1A};
        tbl[6] = '{vc: 2'd0, dt: 6'h00, wc: 16'hFFFF, ecc: 8'h3A};

        for (int n = 0; n < 256; n++) begin
            c = 16'(n);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
            crc_tab[n] = c;
        end

        rst = 1'b1; pkt_valid = 1'b0; pkt_long = 1'b0; pkt_vc = 2'd0; pkt_dt = 6'd0;
        pkt_wc = 16'd0; pl_data = 8'd0; pl_valid = 1'b0; txreadyhs = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset pkt_ready", pkt_ready, 0);
        check("reset txreqhs", txreqhs, 0);
        check("reset txdatahs", txdatahs, 0);
        check("reset busy", busy, 0);
        check("reset underflow", underflow, 0);
        check("reset wc_clamped", wc_clamped, 0);
        rst = 1'b0;

        // Short packets from the table, back to back with the descriptor presented immediately.
        for (int i = 0; i < 7; i++) begin
            pay_src.delete();
            repeat (4) pay_src.push_back(8'($urandom));
            run_pkt(1'b0, tbl[i].vc, tbl[i].dt, tbl[i].wc, 0, -1, -1);
            check($sformatf("tbl%0d length", i), got_q.size(), 4);
            if (got_q.size() == 4) begin
                check($sformatf("tbl%0d DI", i), got_q[0], {tbl[i].vc, tbl[i].dt});
                check($sformatf("tbl%0d WC lo", i), got_q[1], tbl[i].wc[7:0]);
                check($sformatf("tbl%0d WC hi", i), got_q[2], tbl[i].wc[15:8]);
                check($sformatf("tbl%0d ECC", i), got_q[3], tbl[i].ecc);
            end
            check($sformatf("tbl%0d txreqhs cycles", i), req_cycles, 4);
            check($sformatf("tbl%0d pl_ready outside payload", i), pl_ready_out, 0);
            if (i > 0) check($sformatf("tbl%0d request gap", i), gap_seen, GAP + 2);
        end
        check("short wc not clamped", wc_clamped, 0);
        check("busy during gap", busy, 1);

        // Long packet using the CSI-2 example payload. The known CRC is 0x00F0.
        load_example();
        build_exp(1'b1, 2'd0, 6'h2A, 16'd24, -1);
        run_pkt(1'b1, 2'd0, 6'h2A, 16'd24, 0, -1, -1);
        cmp_stream("example");
        check("example ECC", (got_q.size() > 3) ? int'(got_q[3]) : -1, 8'h13);
        check("example CRC lo", (got_q.size() == 30) ? int'(got_q[28]) : -1, 8'hF0);
        check("example CRC hi", (got_q.size() == 30) ? int'(got_q[29]) : -1, 8'h00);
        check("example txreqhs cycles", req_cycles, 30);
        check("example payload consumed", pl_consumed, 24);
        check("example gap", gap_seen, GAP + 2);
        check("example underflow", underflow, 0);

        // Long packet with zero word count: header then FF FF, payload never pulled.
        pay_src.delete();
        repeat (3) pay_src.push_back(8'($urandom));
        build_exp(1'b1, 2'd1, 6'h2B, 16'd0, -1);
        run_pkt(1'b1, 2'd1, 6'h2B, 16'd0, 0, -1, -1);
        cmp_stream("wc0");
        check("wc0 CRC lo", (got_q.size() == 6) ? int'(got_q[4]) : -1, 8'hFF);
        check("wc0 CRC hi", (got_q.size() == 6) ? int'(got_q[5]) : -1, 8'hFF);
        check("wc0 pl_ready pulses", pl_ready_out + pl_consumed, 0);

        // Throttled lane: same byte stream as the unthrottled example.
        load_example();
        build_exp(1'b1, 2'd0, 6'h2A, 16'd24, -1);
        run_pkt(1'b1, 2'd0, 6'h2A, 16'd24, 1, -1, -1);
        cmp_stream("throttled");
        check("throttled hold errors", hold_err, 0);
        check("throttled payload consumed", pl_consumed, 24);

        // Payload starvation for one slot.
        load_example();
        build_exp(1'b1, 2'd2, 6'h2A, 16'd24, 7);
        run_pkt(1'b1, 2'd2, 6'h2A, 16'd24, 0, 7, -1);
        cmp_stream("underflow");
        check("underflow flag", underflow, 1);
        check("underflow payload consumed", pl_consumed, 23);

        // Randomized packets checked against the model.
        for (int r = 0; r < 8; r++) begin
            rlng = 1'($urandom);
            rwc = rlng ? 16'($urandom_range(0, 48)) : 16'($urandom);
            pay_src.delete();
            for (int k = 0; k < 50; k++) pay_src.push_back(8'($urandom));
            build_exp(rlng, 2'($urandom), 6'($urandom), rwc, -1);
            run_pkt(rlng, exp_q[0][7:6], exp_q[0][5:0], rwc, 2, -1, -1);
            cmp_stream($sformatf("random%0d", r));
            check($sformatf("random%0d hold errors", r), hold_err, 0);
            check($sformatf("random%0d pl_ready outside payload", r), pl_ready_out, 0);
            check($sformatf("random%0d gap", r), gap_seen, GAP + 2);
        end
        check("underflow sticky", underflow, 1);

        // Oversized long word count is clamped to WC_MAX.
        pay_src.delete();
        for (int k = 0; k < WCM; k++) pay_src.push_back(8'($urandom));
        build_exp(1'b1, 2'd0, 6'h2A, 16'hFFFF, -1);
        run_pkt(1'b1, 2'd0, 6'h2A, 16'hFFFF, 0, -1, -1);
        check("clamp WC lo", (got_q.size() > 2) ? int'(got_q[1]) : -1, 8'h00);
        check("clamp WC hi", (got_q.size() > 2) ? int'(got_q[2]) : -1, 8'h10);
        check("clamp ECC", (got_q.size() > 3) ? int'(got_q[3]) : -1, 8'h0F);
        check("wc_clamped flag", wc_clamped, 1);
        cmp_stream("clamp");

        // Reset in the middle of the payload, then a clean new packet.
        load_example();
        run_pkt(1'b1, 2'd0, 6'h2A, 16'd24, 0, -1, 10);
        check("pre-reset txreqhs", txreqhs, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid-reset txreqhs", txreqhs, 0);
        check("mid-reset txdatahs", txdatahs, 0);
        check("mid-reset pkt_ready", pkt_ready, 0);
        check("mid-reset pl_ready", pl_ready, 0);
        check("mid-reset busy", busy, 0);
        check("mid-reset underflow", underflow, 0);
        check("mid-reset wc_clamped", wc_clamped, 0);
        rst = 1'b0;
        pay_src.delete();
        build_exp(1'b0, tbl[1].vc, tbl[1].dt, tbl[1].wc, -1);
        run_pkt(1'b0, tbl[1].vc, tbl[1].dt, tbl[1].wc, 0, -1, -1);
        cmp_stream("post-reset");
        check("post-reset txreqhs cycles", req_cycles, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
